// File: rtl/ball_mover_pkg.sv
`default_nettype none
// ============================================================================
// ball_mover_pkg : shared state encodings and default coordinate width
// Revision 1.0
// ============================================================================
package ball_mover_pkg;

  localparam int W_DEFAULT = 10;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_ERASE = 3'd2;
  localparam state_t S_STEP  = 3'd3;
  localparam state_t S_DRAW  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ball_mover_if.sv
`default_nettype none
// ============================================================================
// ball_mover_if : req/done handshake between ball_mover and the pixel drawer
// Revision 1.0
// ============================================================================
interface ball_mover_if #(
  parameter int W = 10
);
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         draw_req;
  logic         erase;
  logic         draw_done;

  modport master (output x, y, draw_req, erase, input draw_done);
  modport slave  (input x, y, draw_req, erase, output draw_done);
endinterface
`default_nettype wire

// File: rtl/ball_mover_axis_step.sv
`default_nettype none
// ============================================================================
// ball_axis_step : one-axis move with clamping to 0..(max-size), no wrap
// Revision 1.0
// ============================================================================
module ball_axis_step
  import ball_mover_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int STEP = 1
) (
  input  logic [W-1:0] p,
  input  logic         du,
  input  logic [W-1:0] max_sz,
  input  logic [W-1:0] size,
  output logic [W-1:0] n
);

  localparam logic [W:0] STEP_V = (W+1)'(STEP);

  logic [W:0] lim;
  logic [W:0] p_ext;
  logic [W:0] sum;
  logic [W:0] diff;
  logic [W:0] res;

  always_comb begin
    lim   = {1'b0, max_sz} - {1'b0, size};
    p_ext = {1'b0, p};
    sum   = p_ext + STEP_V;
    diff  = p_ext - STEP_V;
    if (du) begin
      res = (sum > lim) ? lim : sum;
    end else begin
      res = (p_ext < STEP_V) ? '0 : diff;
      // a shrunk playfield can leave p beyond lim even when moving down
      if (res > lim) begin
        res = lim;
      end
    end
    n = res[W] ? {W{1'b1}} : res[W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/ball_mover.sv
`default_nettype none
// ============================================================================
// ball_mover : owns ball x/y, steps once per tick, sequences erase/draw requests
// Revision 1.0
// ============================================================================
module ball_mover
  import ball_mover_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int STEP    = 1,
  parameter int X_START = 80,
  parameter int Y_START = 60
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         launch,
  input  logic         tick,
  input  logic         x_du,
  input  logic         y_du,
  input  logic [W-1:0] x_max,
  input  logic [W-1:0] y_max,
  input  logic [W-1:0] size,
  ball_mover_if.master drw,
  output logic         busy,
  output logic         overrun
);

  state_t       state;
  state_t       next_state;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] nx, ny;
  logic         req_q, req_d;
  logic         erase_q, erase_d;
  logic         busy_d;
  logic         pending, pend_d;
  logic         ovr_d;
  logic         done_ok;
  logic         in_busy;

  ball_axis_step #(.W(W), .STEP(STEP)) u_step_x (
    .p      (x_q),
    .du     (x_du),
    .max_sz (x_max),
    .size   (size),
    .n      (nx)
  );

  ball_axis_step #(.W(W), .STEP(STEP)) u_step_y (
    .p      (y_q),
    .du     (y_du),
    .max_sz (y_max),
    .size   (size),
    .n      (ny)
  );

  // draw_done only counts while a request is actually outstanding
  assign done_ok = drw.draw_done && req_q;
  assign in_busy = (state == S_ERASE) || (state == S_STEP) || (state == S_DRAW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      x_q     <= W'(X_START);
      y_q     <= W'(Y_START);
      req_q   <= 1'b0;
      erase_q <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= next_state;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      erase_q <= erase_d;
      busy    <= busy_d;
      pending <= pend_d;
      overrun <= ovr_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (launch)            next_state = S_DRAW;
      S_WAIT:  if (tick || pending)   next_state = S_ERASE;
      S_ERASE: if (done_ok)           next_state = S_STEP;
      S_STEP:                         next_state = S_DRAW;
      S_DRAW:  if (done_ok)           next_state = S_WAIT;
      default:                        next_state = S_IDLE;
    endcase
  end

  // registered outputs are computed from next_state so req rises on state entry
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    pend_d = pending;
    ovr_d  = overrun;
    if (state == S_IDLE && launch) begin
      x_d = W'(X_START);
      y_d = W'(Y_START);
    end
    if (state == S_STEP) begin
      x_d = nx;
      y_d = ny;
    end
    if (state == S_WAIT && next_state == S_ERASE) begin
      pend_d = 1'b0;
    end
    if (tick && in_busy) begin
      if (pending) begin
        ovr_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
    req_d   = (next_state == S_ERASE) || (next_state == S_DRAW);
    erase_d = (next_state == S_ERASE);
    busy_d  = req_d || (next_state == S_STEP);
  end

  assign drw.x        = x_q;
  assign drw.y        = y_q;
  assign drw.draw_req = req_q;
  assign drw.erase    = erase_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_mover.sv
`default_nettype none
// ============================================================================
// tb_ball_mover : scoreboard bench; two DUTs (STEP=1 and STEP=4) share stimulus
// Revision 1.0
// ============================================================================
module tb_ball_mover;

  localparam int W = 10;

  typedef struct packed {
    logic         ch;
    logic         erase;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         launch0 = 1'b0, launch1 = 1'b0;
  logic         tick0 = 1'b0, tick1 = 1'b0;
  logic         x_du = 1'b1, y_du = 1'b1;
  logic [W-1:0] x_max = 10'd160, y_max = 10'd160, size = 10'd8;
  logic         busy0, busy1, overrun0, overrun1;
  logic         resp [2];
  logic         done0_force = 1'b0;

  int checks = 0;
  int failures = 0;
  int delay [2];
  int cnt [2];
  exp_t exp_q [$];

  logic         reqs [2];
  logic         ers [2];
  logic [W-1:0] xs [2];
  logic [W-1:0] ys [2];
  logic         prev_req [2];
  logic         hold_e [2];
  logic [W-1:0] hold_x [2];
  logic [W-1:0] hold_y [2];

  always #5 clk = ~clk;

  ball_mover_if #(.W(W)) if0 ();
  ball_mover_if #(.W(W)) if1 ();

  assign if0.draw_done = resp[0] | done0_force;
  assign if1.draw_done = resp[1];

  ball_mover #(.W(W), .STEP(1), .X_START(80), .Y_START(60)) dut0 (
    .clk(clk), .resetn(resetn), .launch(launch0), .tick(tick0),
    .x_du(x_du), .y_du(y_du), .x_max(x_max), .y_max(y_max), .size(size),
    .drw(if0), .busy(busy0), .overrun(overrun0)
  );

  ball_mover #(.W(W), .STEP(4), .X_START(3), .Y_START(150)) dut1 (
    .clk(clk), .resetn(resetn), .launch(launch1), .tick(tick1),
    .x_du(x_du), .y_du(y_du), .x_max(x_max), .y_max(y_max), .size(size),
    .drw(if1), .busy(busy1), .overrun(overrun1)
  );

  assign reqs[0] = if0.draw_req;  assign reqs[1] = if1.draw_req;
  assign ers[0]  = if0.erase;     assign ers[1]  = if1.erase;
  assign xs[0]   = if0.x;         assign xs[1]   = if1.x;
  assign ys[0]   = if0.y;         assign ys[1]   = if1.y;

  initial begin
    for (int c = 0; c < 2; c++) begin
      delay[c] = 3; cnt[c] = 0; resp[c] = 1'b0; prev_req[c] = 1'b0;
      hold_e[c] = 1'b0; hold_x[c] = '0; hold_y[c] = '0;
    end
  end

  // Monitor + drawer model: pops an expectation on each new request, checks
  // the request is held stable, and acks after delay[c] cycles.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reqs[c] && !prev_req[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req ch=%0d actual erase=%0d x=%0d y=%0d required no request",
                   c, ers[c], xs[c], ys[c]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.ch != c[0] || e.erase != ers[c] || e.x != xs[c] || e.y != ys[c]) begin
            failures++;
            $display("FAIL req_content actual ch=%0d erase=%0d x=%0d y=%0d required ch=%0d erase=%0d x=%0d y=%0d",
                     c, ers[c], xs[c], ys[c], e.ch, e.erase, e.x, e.y);
          end
        end
        hold_e[c] = ers[c]; hold_x[c] = xs[c]; hold_y[c] = ys[c];
      end else if (reqs[c] && prev_req[c]) begin
        checks++;
        if (hold_e[c] != ers[c] || hold_x[c] != xs[c] || hold_y[c] != ys[c]) begin
          failures++;
          $display("FAIL req_stable ch=%0d actual erase=%0d x=%0d y=%0d required erase=%0d x=%0d y=%0d",
                   c, ers[c], xs[c], ys[c], hold_e[c], hold_x[c], hold_y[c]);
        end
      end
      if (reqs[c]) begin
        cnt[c]++;
        resp[c] = (cnt[c] == delay[c]);
      end else begin
        cnt[c]  = 0;
        resp[c] = 1'b0;
      end
      prev_req[c] = reqs[c];
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic ch, input logic er, input int px, input int py);
    exp_t e;
    e.ch = ch; e.erase = er; e.x = W'(px); e.y = W'(py);
    exp_q.push_back(e);
  endtask

  task automatic pulse_tick(input int ch);
    @(negedge clk);
    if (ch == 0) tick0 = 1'b1; else tick1 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0; tick1 = 1'b0;
  endtask

  task automatic pulse_launch(input int ch);
    @(negedge clk);
    if (ch == 0) launch0 = 1'b1; else launch1 = 1'b1;
    @(negedge clk);
    launch0 = 1'b0; launch1 = 1'b0;
  endtask

  // Waits until every expected request has been seen and both DUTs are quiet.
  task automatic settle(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !reqs[0] && !reqs[1] && !busy0 && !busy1) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      failures++;
      $display("FAIL %s_timeout actual pending_exp=%0d required 0 within %0d cycles",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_x0", int'(if0.x), 80);
    check("rst_y0", int'(if0.y), 60);
    check("rst_req0", int'(if0.draw_req), 0);
    check("rst_erase0", int'(if0.erase), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_ovr0", int'(overrun0), 0);
    check("rst_x1", int'(if1.x), 3);
    check("rst_y1", int'(if1.y), 150);
    resetn = 1'b1;

    // reset in the middle of an ERASE handshake
    push(0, 0, 80, 60);
    pulse_launch(0);
    settle("launch_a", 200);
    delay[0] = 1000;
    push(0, 1, 80, 60);
    pulse_tick(0);
    repeat (4) @(negedge clk);
    check("mid_erase_req", int'(if0.draw_req), 1);
    check("mid_erase_erase", int'(if0.erase), 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_req0", int'(if0.draw_req), 0);
    check("arst_busy0", int'(busy0), 0);
    check("arst_x0", int'(if0.x), 80);
    check("arst_y0", int'(if0.y), 60);
    check("arst_ovr0", int'(overrun0), 0);
    resetn = 1'b1;
    delay[0] = 3;
    @(negedge clk);
    done0_force = 1'b1;
    @(negedge clk);
    done0_force = 1'b0;
    repeat (4) @(negedge clk);
    check("late_done_req0", int'(if0.draw_req), 0);
    check("late_done_busy0", int'(busy0), 0);
    check("late_done_q", exp_q.size(), 0);

    // launch then three up/right steps
    push(0, 0, 80, 60);
    pulse_launch(0);
    settle("launch_b", 200);
    x_du = 1'b1; y_du = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 80 + i, 60 + i);
      push(0, 0, 81 + i, 61 + i);
      pulse_tick(0);
      settle("step3", 200);
    end
    check("step3_x0", int'(if0.x), 83);
    check("step3_y0", int'(if0.y), 63);
    check("step3_ovr0", int'(overrun0), 0);

    // two ticks during one ERASE: one pended step, one dropped, overrun sticks
    delay[0] = 10;
    push(0, 1, 83, 63); push(0, 0, 84, 64);
    push(0, 1, 84, 64); push(0, 0, 85, 65);
    pulse_tick(0);
    pulse_tick(0);
    pulse_tick(0);
    settle("overrun", 400);
    check("ovr_x0", int'(if0.x), 85);
    check("ovr_y0", int'(if0.y), 65);
    check("ovr_set", int'(overrun0), 1);
    delay[0] = 3;
    push(0, 1, 85, 65); push(0, 0, 86, 66);
    pulse_tick(0);
    settle("ovr_sticky", 200);
    check("ovr_sticky", int'(overrun0), 1);
    check("ovr_sticky_x0", int'(if0.x), 86);

    // launch and tick in the same IDLE cycle
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst2_ovr0", int'(overrun0), 0);
    resetn = 1'b1;
    push(0, 0, 80, 60);
    @(negedge clk);
    launch0 = 1'b1; tick0 = 1'b1;
    @(negedge clk);
    launch0 = 1'b0; tick0 = 1'b0;
    settle("launch_tick", 200);
    repeat (10) @(negedge clk);
    check("lt_busy0", int'(busy0), 0);
    check("lt_x0", int'(if0.x), 80);
    check("lt_y0", int'(if0.y), 60);
    check("lt_ovr0", int'(overrun0), 0);

    // draw_done withheld for 100 cycles
    delay[0] = 100;
    push(0, 1, 80, 60); push(0, 0, 81, 61);
    pulse_tick(0);
    repeat (50) @(negedge clk);
    check("hold_req0", int'(if0.draw_req), 1);
    check("hold_erase0", int'(if0.erase), 1);
    check("hold_x0", int'(if0.x), 80);
    settle("withhold", 1000);
    check("hold_done_x0", int'(if0.x), 81);
    check("hold_done_y0", int'(if0.y), 61);
    delay[0] = 3;

    // STEP=4 clamping at both walls and after the playfield shrinks
    push(1, 0, 3, 150);
    pulse_launch(1);
    settle("launch1", 200);
    x_du = 1'b0; y_du = 1'b1;
    push(1, 1, 3, 150); push(1, 0, 0, 152);
    pulse_tick(1);
    settle("clamp_a", 200);
    check("clamp_x1", int'(if1.x), 0);
    check("clamp_y1", int'(if1.y), 152);
    push(1, 1, 0, 152); push(1, 0, 0, 152);
    pulse_tick(1);
    settle("clamp_b", 200);
    check("wall_x1", int'(if1.x), 0);
    check("wall_y1", int'(if1.y), 152);
    size = 10'd12;
    push(1, 1, 0, 152); push(1, 0, 0, 148);
    pulse_tick(1);
    settle("shrink", 200);
    check("shrink_y1", int'(if1.y), 148);
    check("ch0_untouched_x0", int'(if0.x), 81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
